// File: rtl/picorv32_axil_pkg.sv
// ----------------------------------------------------------------------------
// picorv32_axil_pkg
//   Shared definitions for picorv32_axil_bridge:
//     - axil_state_t : per-transaction FSM state
//     - RESP_*       : AXI response encodings
//     - AXI_PROT_*   : ARPROT/AWPROT values for instruction / data accesses
//     - resp_is_err  : SLVERR and DECERR map to an error completion
// ----------------------------------------------------------------------------
package picorv32_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } axil_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_INSTR = 3'b100;
    localparam logic [2:0] AXI_PROT_DATA  = 3'b000;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/picorv32_axil_bridge.sv
// ----------------------------------------------------------------------------
// picorv32_axil_bridge
//   Registered bridge from the PicoRV32 native memory interface to an
//   AXI4-lite master. Each native request is captured and executed by a
//   per-transaction FSM; AW and W are handshaken independently, the AXI
//   response is reported on mem_err with the one-cycle mem_ready pulse.
//
//   Parameters
//     ADDR_W          address width (native and AXI)
//     DATA_W          data width (32 or 64); strobe width is DATA_W/8
//     TIMEOUT_CYCLES  watchdog limit (>= 2), used only with the macro below
//
//   Ports
//     clk, resetn                         clock / async active-low reset
//     mem_valid, mem_instr, mem_addr,
//     mem_wdata, mem_wstrb                native request (wstrb == 0: read)
//     mem_ready, mem_rdata, mem_err       native completion
//     axi_aw*, axi_w*, axi_b*             AXI4-lite write channels
//     axi_ar*, axi_r*                     AXI4-lite read channels
//
//   Build option
//     PICORV32_AXIL_TIMEOUT_EN  when defined, a watchdog aborts any
//     transaction that stays outside IDLE/DONE for TIMEOUT_CYCLES cycles,
//     completing it with mem_err = 1 and mem_rdata = 0. This drops AXI
//     valids before handshake and is meant for debug / fault recovery only.
// ----------------------------------------------------------------------------
module picorv32_axil_bridge
    import picorv32_axil_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    output logic                  mem_ready,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_err,

    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic [2:0]            axi_awprot,

    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,

    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    input  logic [1:0]            axi_bresp,

    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [ADDR_W-1:0]     axi_araddr,
    output logic [2:0]            axi_arprot,

    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [DATA_W-1:0]     axi_rdata,
    input  logic [1:0]            axi_rresp
);

    localparam int unsigned STRB_W = DATA_W / 8;

    // Empty marker block: shows up in the elaborated hierarchy when the
    // watchdog limit is configured below its minimum.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_too_small
    end

    axil_state_t          state;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [STRB_W-1:0]    wstrb_q;
    logic                 instr_q;
    logic                 aw_ack;
    logic                 w_ack;

`ifdef PICORV32_AXIL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]     tmo_cnt;
`endif

    // Request fields are driven straight from the capture registers.
    assign axi_awaddr = addr_q;
    assign axi_araddr = addr_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;
    assign axi_awprot = AXI_PROT_DATA;
    assign axi_arprot = instr_q ? AXI_PROT_INSTR : AXI_PROT_DATA;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            instr_q     <= 1'b0;
            aw_ack      <= 1'b0;
            w_ack       <= 1'b0;
            mem_ready   <= 1'b0;
            mem_rdata   <= '0;
            mem_err     <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
`ifdef PICORV32_AXIL_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            mem_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        instr_q <= mem_instr;
                        aw_ack  <= 1'b0;
                        w_ack   <= 1'b0;
                        if (|mem_wstrb) begin
                            state       <= WR_REQ;
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                        end else begin
                            state       <= RD_REQ;
                            axi_arvalid <= 1'b1;
                        end
                    end
                end

                WR_REQ: begin
                    if (axi_awvalid && axi_awready) begin
                        aw_ack      <= 1'b1;
                        axi_awvalid <= 1'b0;
                    end
                    if (axi_wvalid && axi_wready) begin
                        w_ack      <= 1'b1;
                        axi_wvalid <= 1'b0;
                    end
                    // A channel not yet acked still has its valid high, so
                    // its ready alone means a handshake at this edge.
                    if ((aw_ack || axi_awready) && (w_ack || axi_wready)) begin
                        state      <= WR_RESP;
                        axi_bready <= 1'b1;
                    end
                end

                WR_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        mem_err    <= resp_is_err(axi_bresp);
                        mem_ready  <= 1'b1;
                        state      <= DONE;
                    end
                end

                RD_REQ: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        mem_rdata  <= axi_rdata;
                        mem_err    <= resp_is_err(axi_rresp);
                        mem_ready  <= 1'b1;
                        state      <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef PICORV32_AXIL_TIMEOUT_EN
            // Placed after the case so the abort overrides any normal
            // progress decided at the same edge.
            if (state == IDLE || state == DONE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
                if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state       <= DONE;
                    axi_awvalid <= 1'b0;
                    axi_wvalid  <= 1'b0;
                    axi_bready  <= 1'b0;
                    axi_arvalid <= 1'b0;
                    axi_rready  <= 1'b0;
                    mem_err     <= 1'b1;
                    mem_rdata   <= '0;
                    mem_ready   <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_picorv32_axil_bridge.sv
`timescale 1ns/1ps
module tb_picorv32_axil_bridge;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 32-bit DUT ----------------
    logic        mem_valid, mem_instr, mem_ready, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic [1:0]  axi_bresp, axi_rresp;

    picorv32_axil_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) u_dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp)
    );

    // ---------------- 64-bit / 40-bit DUT ----------------
    logic        d_mem_valid, d_mem_ready, d_mem_err;
    logic [39:0] d_mem_addr, d_awaddr, d_araddr;
    logic [63:0] d_mem_wdata, d_mem_rdata, d_wdata;
    logic [7:0]  d_mem_wstrb, d_wstrb;
    logic        d_awvalid, d_wvalid, d_bvalid, d_bready, d_arvalid, d_rready;
    logic [2:0]  d_awprot, d_arprot;

    picorv32_axil_bridge #(.ADDR_W(40), .DATA_W(64)) u_dut64 (
        .clk(clk), .resetn(resetn),
        .mem_valid(d_mem_valid), .mem_instr(1'b0), .mem_addr(d_mem_addr),
        .mem_wdata(d_mem_wdata), .mem_wstrb(d_mem_wstrb), .mem_ready(d_mem_ready),
        .mem_rdata(d_mem_rdata), .mem_err(d_mem_err),
        .axi_awvalid(d_awvalid), .axi_awready(1'b1),
        .axi_awaddr(d_awaddr), .axi_awprot(d_awprot),
        .axi_wvalid(d_wvalid), .axi_wready(1'b1),
        .axi_wdata(d_wdata), .axi_wstrb(d_wstrb),
        .axi_bvalid(d_bvalid), .axi_bready(d_bready), .axi_bresp(2'b00),
        .axi_arvalid(d_arvalid), .axi_arready(1'b1),
        .axi_araddr(d_araddr), .axi_arprot(d_arprot),
        .axi_rvalid(1'b0), .axi_rready(d_rready),
        .axi_rdata(64'h0), .axi_rresp(2'b00)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [63:0] addr; logic [2:0] prot; } addr_exp_t;
    typedef struct packed { logic [63:0] data; logic [7:0] strb; } wdat_exp_t;
    typedef struct packed { logic [31:0] rdata; logic err; int lat; } done_exp_t;

    addr_exp_t q_aw[$], q_ar[$], q_aw64[$];
    wdat_exp_t q_w[$], q_w64[$];
    done_exp_t q_done[$];

    int applied = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        applied++;
        miscompares++;
        $display("FAIL %s: event outcome differs from required (t=%0t)", name, $time);
    endtask

    // slave configuration
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    bit ar_hold = 1'b0;

    int aw_hs = 0, w_hs = 0, ar_pending = 0;   // completed handshakes awaiting a response
    int tx_aw = 0, tx_w = 0;                   // handshakes within the current write
    bit cur_aw = 1'b0, cur_w = 1'b0;
    int issue_cyc = 0;
    logic [31:0] last_rdata = '0;

    // ---------------- AXI slave model ----------------
    initial begin : aw_slave
        addr_exp_t e;
        axi_awready = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && axi_awvalid) begin
                for (int i = 0; i < aw_dly; i++) begin
                    @(negedge clk);
                    check("awvalid stable", axi_awvalid, 1);
                end
                axi_awready = 1'b1; cur_aw = 1'b1; tx_aw++;
                if (q_aw.size() == 0) flag("aw unexpected");
                else begin
                    e = q_aw.pop_front();
                    check("awaddr", axi_awaddr, e.addr);
                    check("awprot", axi_awprot, e.prot);
                end
                @(negedge clk);
                axi_awready = 1'b0; aw_hs++;
                check("awvalid drop", axi_awvalid, 0);
            end
        end
    end

    initial begin : w_slave
        wdat_exp_t e;
        axi_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && axi_wvalid) begin
                for (int i = 0; i < w_dly; i++) begin
                    @(negedge clk);
                    check("wvalid stable", axi_wvalid, 1);
                end
                axi_wready = 1'b1; cur_w = 1'b1; tx_w++;
                if (q_w.size() == 0) flag("w unexpected");
                else begin
                    e = q_w.pop_front();
                    check("wdata", axi_wdata, e.data);
                    check("wstrb", axi_wstrb, e.strb);
                end
                @(negedge clk);
                axi_wready = 1'b0; w_hs++;
                check("wvalid drop", axi_wvalid, 0);
            end
        end
    end

    initial begin : b_slave
        axi_bvalid = 1'b0; axi_bresp = 2'b00;
        forever begin
            @(negedge clk); #1;
            if (aw_hs > 0 && w_hs > 0) begin
                aw_hs--; w_hs--;
                repeat (b_dly) @(negedge clk);
                axi_bvalid = 1'b1; axi_bresp = bresp_cfg;
                for (int i = 0; i < 200; i++) begin
                    if (axi_bready) begin @(negedge clk); break; end
                    @(negedge clk);
                end
                axi_bvalid = 1'b0; axi_bresp = 2'b00;
            end
        end
    end

    initial begin : ar_slave
        addr_exp_t e;
        axi_arready = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn && axi_arvalid && !ar_hold) begin
                for (int i = 0; i < ar_dly; i++) begin
                    @(negedge clk);
                    check("arvalid stable", axi_arvalid, 1);
                end
                axi_arready = 1'b1;
                if (q_ar.size() == 0) flag("ar unexpected");
                else begin
                    e = q_ar.pop_front();
                    check("araddr", axi_araddr, e.addr);
                    check("arprot", axi_arprot, e.prot);
                end
                @(negedge clk);
                axi_arready = 1'b0; ar_pending++;
                check("arvalid drop", axi_arvalid, 0);
            end
        end
    end

    initial begin : r_slave
        bit abort;
        axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
        forever begin
            @(negedge clk); #1;
            if (ar_pending > 0) begin
                abort = 1'b0;
                ar_pending--;
                for (int i = 0; i < r_dly; i++) begin
                    @(negedge clk);
                    if (!resetn) begin abort = 1'b1; break; end
                end
                if (!abort) begin
                    axi_rvalid = 1'b1; axi_rdata = rdata_cfg; axi_rresp = rresp_cfg;
                    for (int i = 0; i < 200; i++) begin
                        if (axi_rready) begin @(negedge clk); break; end
                        @(negedge clk);
                    end
                end
                axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = 2'b00;
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin : done_mon
        done_exp_t e;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                if (q_done.size() == 0) flag("mem_ready unexpected");
                else begin
                    e = q_done.pop_front();
                    check("mem_err", mem_err, e.err);
                    check("mem_rdata", mem_rdata, e.rdata);
                    if (e.lat >= 0) check("latency", cyc - issue_cyc, e.lat);
                end
                @(negedge clk);
                check("mem_ready width", mem_ready, 0);
            end
        end
    end

    initial begin : bready_mon
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (axi_bready && !prev) check("bready after AW and W", cur_aw && cur_w, 1);
            prev = axi_bready;
        end
    end

    initial begin : mon64
        addr_exp_t ea;
        wdat_exp_t ew;
        forever begin
            @(negedge clk);
            if (d_awvalid || d_wvalid) begin
                if (q_aw64.size() == 0 || q_w64.size() == 0) flag("64b write unexpected");
                else begin
                    ea = q_aw64.pop_front();
                    ew = q_w64.pop_front();
                    check("64b awvalid+wvalid", {d_awvalid, d_wvalid}, 2'b11);
                    check("64b awaddr", d_awaddr, ea.addr);
                    check("64b awprot", d_awprot, ea.prot);
                    check("64b wdata", d_wdata, ew.data);
                    check("64b wstrb", d_wstrb, ew.strb);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic exp_read(input logic [31:0] addr, input bit instr,
                            input logic [31:0] rdata, input bit err, input int lat);
        q_ar.push_back('{addr: {32'h0, addr}, prot: {instr, 2'b00}});
        q_done.push_back('{rdata: rdata, err: err, lat: lat});
        last_rdata = rdata;
    endtask

    task automatic exp_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input bit err, input int lat);
        q_aw.push_back('{addr: {32'h0, addr}, prot: 3'b000});
        q_w.push_back('{data: {32'h0, data}, strb: {4'h0, strb}});
        q_done.push_back('{rdata: last_rdata, err: err, lat: lat});
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (mem_ready) return;
        end
        flag("mem_ready timeout");
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit instr,
                          input bit hold_valid, input bit wait_for_done);
        @(negedge clk);
        mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_instr = instr;
        mem_valid = 1'b1;
        issue_cyc = cyc;
        cur_aw = 1'b0; cur_w = 1'b0; tx_aw = 0; tx_w = 0;
        if (!hold_valid) begin
            @(negedge clk);
            mem_valid = 1'b0;
        end
        if (wait_for_done) begin
            wait_done(300);
            mem_valid = 1'b0;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " mem_ready"}, mem_ready, 0);
        check({tag, " mem_err"}, mem_err, 0);
        check({tag, " mem_rdata"}, mem_rdata, 0);
        check({tag, " valids/readies"},
              {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 5'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int bad;
        resetn = 1'b0;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        d_mem_valid = 1'b0; d_mem_addr = '0; d_mem_wdata = '0; d_mem_wstrb = '0; d_bvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        resetn = 1'b1;

        // zero-wait instruction read
        rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b00;
        exp_read(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
        do_req(32'h0000_1000, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);

        // zero-wait full-word write, mem_rdata must hold
        exp_write(32'h0000_2004, 32'h1122_3344, 4'hF, 1'b0, 3);
        do_req(32'h0000_2004, 32'h1122_3344, 4'hF, 1'b0, 1'b1, 1'b1);

        // AW accepted 3 cycles before W: W handshake edge 4, bvalid cycle 5, mem_ready cycle 6
        w_dly = 3;
        exp_write(32'h0000_2008, 32'hA5A5_5A5A, 4'b0101, 1'b0, 6);
        do_req(32'h0000_2008, 32'hA5A5_5A5A, 4'b0101, 1'b0, 1'b1, 1'b1);
        check("AW handshake count", tx_aw, 1);
        check("W handshake count", tx_w, 1);
        w_dly = 0;

        // SLVERR write with mem_valid dropped after capture; bvalid 2 cycles late
        b_dly = 2; bresp_cfg = 2'b10;
        exp_write(32'h0000_3000, 32'hFFFF_0000, 4'b1100, 1'b1, 5);
        do_req(32'h0000_3000, 32'hFFFF_0000, 4'b1100, 1'b0, 1'b0, 1'b1);
        b_dly = 0; bresp_cfg = 2'b00;

        // DECERR data read with AR and R wait states: still captures rdata
        ar_dly = 2; r_dly = 1; rresp_cfg = 2'b11; rdata_cfg = 32'hCAFE_F00D;
        exp_read(32'h0000_3004, 1'b0, 32'hCAFE_F00D, 1'b1, 6);
        do_req(32'h0000_3004, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        ar_dly = 0; r_dly = 0;

        // EXOKAY read is not an error
        rresp_cfg = 2'b01; rdata_cfg = 32'h0BAD_C0DE;
        exp_read(32'h0000_3008, 1'b0, 32'h0BAD_C0DE, 1'b0, 3);
        do_req(32'h0000_3008, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        rresp_cfg = 2'b00;

        // DECERR write
        bresp_cfg = 2'b11;
        exp_write(32'h0000_300C, 32'h0000_00EE, 4'b0001, 1'b1, 3);
        do_req(32'h0000_300C, 32'h0000_00EE, 4'b0001, 1'b0, 1'b1, 1'b1);
        bresp_cfg = 2'b00;

        // reset while waiting in RD_RESP: no completion, outputs cleared at once
        r_dly = 6; rdata_cfg = 32'h7777_7777;
        q_ar.push_back('{addr: 64'h4000, prot: 3'b000});
        do_req(32'h0000_4000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        bad = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (axi_rready) begin bad = 0; break; end
        end
        check("reached RD_RESP", bad, 0);
        #2 resetn = 1'b0;
        #1 check_idle_outputs("async reset");
        mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        r_dly = 0;
        last_rdata = 32'h0;

        // clean restart after reset
        exp_write(32'h0000_5000, 32'h1357_9BDF, 4'b0011, 1'b0, 3);
        do_req(32'h0000_5000, 32'h1357_9BDF, 4'b0011, 1'b0, 1'b1, 1'b1);
        check("post-reset AW count", tx_aw, 1);
        rdata_cfg = 32'h2468_ACE0;
        exp_read(32'h0000_5004, 1'b1, 32'h2468_ACE0, 1'b0, 3);
        do_req(32'h0000_5004, 32'h0, 4'h0, 1'b1, 1'b1, 1'b1);

        // hung read address channel
        ar_hold = 1'b1;
`ifdef PICORV32_AXIL_TIMEOUT_EN
        q_done.push_back('{rdata: 32'h0, err: 1'b1, lat: 17});
        last_rdata = 32'h0;
        do_req(32'h0000_6000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        check("timeout arvalid", axi_arvalid, 0);
        ar_hold = 1'b0;
`else
        do_req(32'h0000_6000, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!axi_arvalid || mem_ready) bad++;
        end
        check("hung RD_REQ held 1000 cycles", bad, 0);
        rdata_cfg = 32'h600D_600D;
        exp_read(32'h0000_6000, 1'b0, 32'h600D_600D, 1'b0, -1);
        ar_hold = 1'b0;
        wait_done(50);
        mem_valid = 1'b0;
`endif

        // 64-bit data / 40-bit address instance
        q_aw64.push_back('{addr: 64'hAB_CDEF_0123, prot: 3'b000});
        q_w64.push_back('{data: 64'h0123_4567_89AB_CDEF, strb: 8'hF0});
        @(negedge clk);
        d_mem_addr = 40'hAB_CDEF_0123; d_mem_wdata = 64'h0123_4567_89AB_CDEF;
        d_mem_wstrb = 8'hF0; d_mem_valid = 1'b1;
        @(negedge clk);
        d_mem_valid = 1'b0;
        @(negedge clk);
        check("64b bready", d_bready, 1);
        d_bvalid = 1'b1;
        @(negedge clk);
        d_bvalid = 1'b0;
        check("64b mem_ready", d_mem_ready, 1);
        check("64b mem_err", d_mem_err, 0);

        repeat (5) @(negedge clk);
        check("scoreboard drained", q_done.size() + q_aw.size() + q_w.size() + q_ar.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global timeout: simulation still running at %0t", $time);
        $fatal(1, "bench watchdog expired");
    end

endmodule
